// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder.
// FSM state encoding and default operand width.
package adder_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell.
// Pure combinational bit-slice.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder, one bit per clock.
// start/busy/done handshake; result held until the next completion.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] a_nx;
    logic [WIDTH-1:0] b_nx;
    logic [WIDTH-1:0] s_nx;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last;

    fulladder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    assign accept = start && (state != SHIFT);
    assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: DONE accepts a new start just like IDLE.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last) state_nx = DONE;
            DONE:    state_nx = start ? SHIFT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shifted operand/result values; new sum bit enters at the MSB.
    always_comb begin
        a_nx = a_sr >> 1;
        b_nx = b_sr >> 1;
        s_nx = s_sr >> 1;
        s_nx[WIDTH-1] = fa_s;
    end

    // Datapath: load on accept, shift while busy, publish on last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr  <= a_nx;
            b_sr  <= b_nx;
            s_sr  <= s_nx;
            carry <= fa_co;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= s_nx;
                cout <= fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder.
// Cycle model for WIDTH=8 plus exhaustive WIDTH=1 and WIDTH=4 sweeps.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       s1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       c1 = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    logic       s4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       c4 = 1'b0;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    int       m_cnt = 0;
    bit       m_done = 1'b0;
    bit [8:0] m_res = '0;
    bit [8:0] m_pend = '0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .cin(c1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .cin(c4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endfunction

    // Model: an accepted add keeps the unit busy for 8 cycles,
    // then a one-cycle done publishes a+b+cin.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else if (m_cnt == 0 && start) begin
            m_cnt  <= 8;
            m_pend <= 9'(a) + 9'(b) + 9'(cin);
            m_done <= 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_res  <= m_pend;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("cycle", 32'({busy, done, cout, sum}),
                  32'({m_cnt != 0, m_done, m_res}));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat, output int nbusy);
        lat = 0;
        nbusy = 0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
            tick();
        end
        if (lat == 0) check("timeout", 0, 1);
    endtask

    task automatic run_op(input logic [7:0] ai, input logic [7:0] bi,
                          input logic ci, input bit mutate,
                          output int lat, output int nbusy);
        a = ai;
        b = bi;
        cin = ci;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (mutate) begin
            a = 8'h33;
            b = 8'h33;
            cin = 1'b0;
        end
        wait_done(lat, nbusy);
    endtask

    task automatic op1(input logic ai, input logic bi, input logic ci);
        bit ok;
        a1 = ai;
        b1 = bi;
        c1 = ci;
        s1 = 1'b1;
        tick();
        s1 = 1'b0;
        ok = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (done1) begin
                ok = (k == 2) && !busy1;
                break;
            end
            tick();
        end
        check("w1_timing", 32'(ok), 1);
        check("w1_sum", 32'({cout1, sum1}), 32'(ai) + 32'(bi) + 32'(ci));
        tick();
    endtask

    task automatic op4(input logic [3:0] ai, input logic [3:0] bi, input logic ci);
        bit ok;
        a4 = ai;
        b4 = bi;
        c4 = ci;
        s4 = 1'b1;
        tick();
        s4 = 1'b0;
        ok = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (done4) begin
                ok = (k == 5) && !busy4;
                break;
            end
            tick();
        end
        check("w4_timing", 32'(ok), 1);
        check("w4_sum", 32'({cout4, sum4}), 32'(ai) + 32'(bi) + 32'(ci));
    endtask

    initial begin
        int lat;
        int nb;
        int nd;
        logic [8:0] got;
        logic [7:0] ra;
        logic [7:0] rb;
        logic rc;

        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_sum", 32'(sum), 0);
        check("reset_cout", 32'(cout), 0);
        rst = 1'b0;
        tick();

        run_op(8'h00, 8'h00, 1'b0, 1'b0, lat, nb);
        check("zero_latency", 32'(lat), 9);
        check("zero_busy_cycles", 32'(nb), 8);
        check("zero_result", 32'({cout, sum}), 9'h000);
        tick();

        run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat, nb);
        check("ff_plus_1", 32'({cout, sum}), 9'h100);
        tick();
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, lat, nb);
        check("7f_plus_1", 32'({cout, sum}), 9'h080);
        tick();

        run_op(8'hA5, 8'h5A, 1'b1, 1'b1, lat, nb);
        check("a5_5a_cin_mutated", 32'({cout, sum}), 9'h100);
        tick();

        a = 8'h12;
        b = 8'h34;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        nd = 0;
        got = '0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                nd++;
                got = {cout, sum};
            end
            tick();
        end
        check("busy_start_done_count", 32'(nd), 1);
        check("busy_start_sum", 32'(got), 9'h046);

        run_op(8'h40, 8'h05, 1'b0, 1'b0, lat, nb);
        check("b2b_first", 32'({cout, sum}), 9'h045);
        a = 8'h10;
        b = 8'h20;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy_next", 32'(busy), 1);
        check("b2b_sum_held", 32'({cout, sum}), 9'h045);
        wait_done(lat, nb);
        check("b2b_latency", 32'(lat), 9);
        check("b2b_second", 32'({cout, sum}), 9'h030);
        tick();

        a = 8'h55;
        b = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) nd++;
            tick();
        end
        check("rst_no_done", 32'(nd), 0);

        rst = 1'b1;
        start = 1'b1;
        a = 8'h01;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("rst_beats_start", 32'(busy), 0);
        tick();

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            run_op(ra, rb, rc, 1'b0, lat, nb);
            check("rand", 32'({cout, sum}), 32'(ra) + 32'(rb) + 32'(rc));
            if (i % 2 == 1) tick();
        end
        tick();

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op1(v[2], v[1], v[0]);
        end

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            op4(v[8:5], v[4:1], v[0]);
        end
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial WIDTH-bit adder built around the team's existing single-bit `fulladder` cell. A carry flip-flop feeds `cout` back into `cin` each cycle, so one full adder covers an N-bit add in N clocks. It sits upstream of result consumers that tolerate multi-cycle latency and replaces a WIDTH-wide ripple array where area matters. The start/busy/done handshake lets a controller issue back-to-back operations.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous reset, active-high
start  input   1      request an add; accepted only when busy=0
a      input   WIDTH  operand A; sampled on the accepting edge only
b      input   WIDTH  operand B; sampled on the accepting edge only
cin    input   1      carry-in; sampled on the accepting edge only
busy   output  1      high while a bit-serial add is in progress
done   output  1      one-cycle pulse; sum/cout valid from this cycle
sum    output  WIDTH  registered result; held until the next completion
cout   output  1      registered carry-out; held until the next completion

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, bit counter and carry FF all 0.
- FSM states:
  - IDLE: wait for start.
  - SHIFT: one operand bit per cycle.
  - DONE: publish result.
- IDLE, start=1: load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0; go to SHIFT.
- SHIFT, each cycle:
  - The fulladder takes a_sr[0], b_sr[0] and carry.
  - a_sr and b_sr shift right by one.
  - The fulladder's s shifts into the MSB of s_sr (right shift).
  - carry<=fulladder cout; cnt<=cnt+1.
  - When cnt=WIDTH-1: sum<=final s_sr value (including this cycle's bit), cout<=fulladder cout; go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back); next state is SHIFT.
  - Otherwise go to IDLE.
- busy: 1 in SHIFT only. Combinational from state, or registered equivalently.
- done: 1 in DONE only.
- Latency: start accepted at edge N; busy=1 for cycles N+1..N+WIDTH; done=1 in cycle N+WIDTH+1. Throughput is one add per WIDTH+1 cycles.
- Result outputs: sum and cout change only on the edge entering DONE. They stay stable during the following operation's SHIFT cycles.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), no saturation. Counter width is $clog2(WIDTH+1).
- start while busy=1 is ignored: no queuing, no error flag.
- a, b and cin may change freely after the accepting edge.
- rst asserted mid-SHIFT or in DONE: the next edge forces IDLE and zeroes all outputs. The partial result is discarded.
- rst and start in the same cycle: reset wins.
- WIDTH=1: exactly one SHIFT cycle. Timing rules are unchanged.

Decomposition:
- Shared package `adder_pkg`:
  - state enum/localparams: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - WIDTH default constant.
- Sub-module: instantiate the existing `fulladder` (ports a, b, cin, s, cout) once as the bit-slice. No new sub-module.
- Top-level logic: FSM, counter, shift registers, carry FF, result registers.

Test Plan:
- WIDTH=8; a=8'h00, b=8'h00, cin=0, start pulsed -> busy high 8 cycles; done in cycle N+9; sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0.
- a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Changing a/b to 8'h33 during busy does not alter the result.
- start re-pulsed at cycle N+3 (busy) -> ignored; one done only; result from the first operands. start held in the DONE cycle -> second add begins; busy the next cycle; previous sum held until the new done.
- rst at cycle N+4 mid-SHIFT -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse follows.
- Random sweep: 1000 random a/b/cin at WIDTH=8, plus exhaustive at WIDTH=1 and WIDTH=4, checked against a+b+cin -> zero mismatches.
